// File: rtl/renkon_feat_reader_pkg.sv
// renkon_feat_reader_pkg: shared defaults and FSM encoding for the feature reader.
package renkon_feat_reader_pkg;
   localparam int RENKON_DWIDTH = 16;
   localparam int RENKON_FACCUM = 10;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} rfr_state_e;
endpackage

// File: rtl/renkon_feat_reader_buf.sv
// renkon_feat_reader_buf: 2-entry output buffer (head + skid) with registered outputs.
module renkon_feat_reader_buf
   import renkon_feat_reader_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     wr_en,
   input  logic signed [DWIDTH-1:0] wr_data,
   input  logic                     rd_ready,
   output logic                     out_valid,
   output logic signed [DWIDTH-1:0] out_data,
   output logic [1:0]               count
);
   logic head_v_q, head_v_d, skid_v_q, skid_v_d;
   logic signed [DWIDTH-1:0] head_q, head_d, skid_q, skid_d;
   // skid is always older than an incoming word, so it refills the head first
   always_comb begin
      head_v_d = head_v_q & ~rd_ready;
      head_d   = head_q;
      skid_v_d = skid_v_q;
      skid_d   = skid_q;
      if (!head_v_d && skid_v_d) begin
         head_v_d = 1'b1;
         head_d   = skid_q;
         skid_v_d = 1'b0;
      end
      if (wr_en && !head_v_d) begin
         head_v_d = 1'b1;
         head_d   = wr_data;
      end else if (wr_en) begin
         skid_v_d = 1'b1;
         skid_d   = wr_data;
      end
   end
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         head_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         head_q   <= '0;
         skid_q   <= '0;
      end else begin
         head_v_q <= head_v_d;
         skid_v_q <= skid_v_d;
         head_q   <= head_d;
         skid_q   <= skid_d;
      end
   end
   assign out_valid = head_v_q;
   assign out_data  = head_q;
   assign count     = {1'b0, head_v_q} + {1'b0, skid_v_q};
endmodule

// File: rtl/renkon_feat_reader.sv
// renkon_feat_reader: streams len words from a 1-cycle-latency feature memory starting at base_addr.
// Define RENKON_FEAT_READER_STRIDE_EN to add a per-job address stride input (otherwise stride is 1).
module renkon_feat_reader
   import renkon_feat_reader_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH,
   parameter int FACCUM = RENKON_FACCUM
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  logic                     req,
   input  logic [FACCUM-1:0]        base_addr,
   input  logic [FACCUM:0]          len,
`ifdef RENKON_FEAT_READER_STRIDE_EN
   input  logic [FACCUM-1:0]        stride,
`endif
   output logic [FACCUM-1:0]        mem_addr,
   input  logic signed [DWIDTH-1:0] read_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DWIDTH-1:0] out_data,
   output logic                     busy,
   output logic                     done
);
   localparam logic [FACCUM:0] ONE = 1;
   rfr_state_e state_q, state_d;
   logic [FACCUM-1:0] addr_q, addr_d, step_q, step_d, stride_in;
   logic [FACCUM:0] issue_left_q, issue_left_d, out_left_q, out_left_d;
   logic inflight_q, inflight_d, done_q, done_d, issue, xfer;
   logic [1:0] buf_cnt;
`ifdef RENKON_FEAT_READER_STRIDE_EN
   assign stride_in = stride;
`else
   assign stride_in = FACCUM'(1);
`endif
   assign xfer  = out_valid & out_ready;
   // never commit a read whose data might find the buffer full when it lands
   assign issue = (state_q == ST_ISSUE) &&
                  (({1'b0, buf_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, xfer}));
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      step_d       = step_q;
      issue_left_d = issue_left_q;
      out_left_d   = xfer ? out_left_q - ONE : out_left_q;
      inflight_d   = issue;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            done_d = req && (len == '0);
            if (req && (len != '0)) begin
               state_d      = ST_ISSUE;
               addr_d       = base_addr;
               step_d       = stride_in;
               issue_left_d = len;
               out_left_d   = len;
            end
         end
         ST_ISSUE: begin
            addr_d       = issue ? addr_q + step_q : addr_q;
            issue_left_d = issue ? issue_left_q - ONE : issue_left_q;
            state_d      = (issue && issue_left_q == ONE) ? ST_DRAIN : ST_ISSUE;
         end
         ST_DRAIN: state_d = ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase
      if (xfer && out_left_q == ONE) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         step_q       <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         inflight_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         step_q       <= step_d;
         issue_left_q <= issue_left_d;
         out_left_q   <= out_left_d;
         inflight_q   <= inflight_d;
         done_q       <= done_d;
      end
   end
   renkon_feat_reader_buf #(.DWIDTH(DWIDTH)) u_buf (
      .clk      (clk),
      .xrst     (xrst),
      .wr_en    (inflight_q),
      .wr_data  (read_data),
      .rd_ready (out_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .count    (buf_cnt)
   );
   assign mem_addr = addr_q;
   assign busy     = state_q != ST_IDLE;
   assign done     = done_q;
endmodule

// File: tb/tb_renkon_feat_reader.sv
// tb_renkon_feat_reader: randomized self-checking bench with a memory model and an address-order reference.
module tb_renkon_feat_reader;
   localparam int DW = 16;
   localparam int FA = 10;
   localparam int DEPTH = 1 << FA;
   logic clk = 1'b0;
   logic xrst = 1'b1;
   logic req = 1'b0;
   logic out_ready = 1'b1;
   logic [FA-1:0] base_addr = '0;
   logic [FA:0] len = '0;
`ifdef RENKON_FEAT_READER_STRIDE_EN
   logic [FA-1:0] stride = FA'(1);
`endif
   logic [FA-1:0] mem_addr;
   logic signed [DW-1:0] read_data = '0;
   logic signed [DW-1:0] out_data;
   logic out_valid, busy, done;
   logic signed [DW-1:0] mem [DEPTH];
   logic signed [DW-1:0] got [$];
   int total = 0;
   int bad = 0;
   int first_idx, last_idx, done_idx, done_cnt, done_busy, busy_seen, stall_bad, over2, hold_bad;

   renkon_feat_reader #(.DWIDTH(DW), .FACCUM(FA)) dut (
      .clk      (clk),
      .xrst     (xrst),
      .req      (req),
      .base_addr(base_addr),
      .len      (len),
`ifdef RENKON_FEAT_READER_STRIDE_EN
      .stride   (stride),
`endif
      .mem_addr (mem_addr),
      .read_data(read_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) read_data <= mem[mem_addr];

   function automatic int exp_addr(input int b, input int i, input int s);
`ifdef RENKON_FEAT_READER_STRIDE_EN
      return (b + i * s) % DEPTH;
`else
      return (b + i) % DEPTH;
`endif
   endfunction

   // mode: 0 ready=1, 1 ready pattern 1,0,0, 2 random, 3 ready low for 12 cycles then 1
   task automatic do_job(input int b, input int l, input int s, input int mode, input bit intf);
      int ncyc = 6 * l + 20;
      logic stall_prev = 1'b0;
      logic full_prev = 1'b0;
      logic signed [DW-1:0] data_prev = '0;
      logic [FA-1:0] addr_prev = '0;
      got.delete();
      first_idx = -1; last_idx = -1; done_idx = -1; done_cnt = 0; done_busy = 0;
      busy_seen = 0; stall_bad = 0; over2 = 0; hold_bad = 0;
      req = 1'b1;
      base_addr = FA'(b);
      len = (FA+1)'(l);
`ifdef RENKON_FEAT_READER_STRIDE_EN
      stride = FA'(s);
`endif
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (c % 3 == 0);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (c >= 12);
         endcase
         if (intf) begin
            req = (c == 2);
            base_addr = FA'($urandom);
            len = (FA+1)'($urandom_range(1, 9));
`ifdef RENKON_FEAT_READER_STRIDE_EN
            stride = FA'($urandom);
`endif
         end
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = c;
            if (busy) done_busy++;
         end
         if (stall_prev && (out_valid !== 1'b1 || out_data !== data_prev)) stall_bad++;
         if (full_prev && mem_addr !== addr_prev) hold_bad++;
         if (dut.u_buf.count > 2'd2) over2++;
         full_prev = (dut.u_buf.count == 2'd2) && !(out_valid && out_ready);
         stall_prev = out_valid && !out_ready;
         data_prev = out_data;
         addr_prev = mem_addr;
         if (out_valid && out_ready) begin
            if (first_idx < 0) first_idx = c;
            last_idx = c;
            got.push_back(out_data);
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_words(input string name, input int b, input int l, input int s);
      total++;
      if (got.size() !== l) begin
         bad++;
         $display("FAIL %s count: got %0d words, expected %0d", name, got.size(), l);
      end
      for (int i = 0; i < got.size() && i < l; i++) begin
         total++;
         if (got[i] !== mem[exp_addr(b, i, s)]) begin
            bad++;
            $display("FAIL %s word%0d: got %0h, expected %0h (addr %0d)", name, i, got[i],
                     mem[exp_addr(b, i, s)], exp_addr(b, i, s));
         end
      end
   endtask

   task automatic test_reset();
      #1 xrst = 1'b0;
      #1;
      total++;
      if ({mem_addr, out_valid, out_data, busy, done} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got addr=%0h v=%b d=%0h busy=%b done=%b, expected all 0",
                  mem_addr, out_valid, out_data, busy, done);
      end
      @(posedge clk); @(posedge clk); #1;
      xrst = 1'b1;
   endtask

   task automatic test_basic();
      do_job(5, 4, 1, 0, 1'b0);
      check_words("basic", 5, 4, 1);
      total++;
      if (first_idx !== 2) begin bad++; $display("FAIL basic_latency: got %0d, expected 2", first_idx); end
      total++;
      if (last_idx !== 5) begin bad++; $display("FAIL basic_throughput: last word at %0d, expected 5", last_idx); end
      total++;
      if (done_idx !== 6 || done_cnt !== 1) begin
         bad++; $display("FAIL basic_done: at %0d count %0d, expected at 6 count 1", done_idx, done_cnt);
      end
      total++;
      if (done_busy !== 0) begin bad++; $display("FAIL basic_busy_at_done: got %0d, expected 0", done_busy); end
   endtask

   task automatic test_len0();
      do_job(7, 0, 1, 0, 1'b0);
      total++;
      if (got.size() !== 0) begin bad++; $display("FAIL len0_words: got %0d, expected 0", got.size()); end
      total++;
      if (done_cnt !== 1 || done_idx !== 0) begin
         bad++; $display("FAIL len0_done: count %0d at %0d, expected 1 at 0", done_cnt, done_idx);
      end
      total++;
      if (busy_seen !== 0) begin bad++; $display("FAIL len0_busy: got %0d busy cycles, expected 0", busy_seen); end
   endtask

   task automatic test_wrap();
      do_job(DEPTH - 2, 4, 1, 0, 1'b0);
      check_words("wrap", DEPTH - 2, 4, 1);
   endtask

   task automatic test_stall();
      do_job(300, 8, 1, 1, 1'b0);
      check_words("stall", 300, 8, 1);
      total++;
      if (stall_bad !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes, expected 0", stall_bad); end
      total++;
      if (over2 !== 0) begin bad++; $display("FAIL stall_depth: got %0d overfills, expected 0", over2); end
      total++;
      if (done_cnt !== 1) begin bad++; $display("FAIL stall_done: got %0d, expected 1", done_cnt); end
   endtask

   task automatic test_hold();
      do_job(600, 6, 1, 3, 1'b0);
      check_words("hold", 600, 6, 1);
      total++;
      if (hold_bad !== 0) begin bad++; $display("FAIL hold_addr: got %0d moves, expected 0", hold_bad); end
      total++;
      if (stall_bad !== 0 || over2 !== 0) begin
         bad++; $display("FAIL hold_buffer: stall=%0d over=%0d, expected 0 0", stall_bad, over2);
      end
      total++;
      if (first_idx !== 12) begin bad++; $display("FAIL hold_first: got %0d, expected 12", first_idx); end
   endtask

   task automatic test_abort();
      int n = 0;
      int late = 0;
      req = 1'b1; base_addr = FA'(100); len = (FA+1)'(10); out_ready = 1'b1;
`ifdef RENKON_FEAT_READER_STRIDE_EN
      stride = FA'(1);
`endif
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) n++;
         if (n == 3) break;
         @(posedge clk); #1;
      end
      total++;
      if (n !== 3) begin bad++; $display("FAIL abort_progress: got %0d words, expected 3", n); end
      xrst = 1'b0;
      #1;
      total++;
      if ({mem_addr, out_valid, out_data, busy, done} !== '0) begin
         bad++;
         $display("FAIL abort_outputs: got addr=%0h v=%b d=%0h busy=%b done=%b, expected all 0",
                  mem_addr, out_valid, out_data, busy, done);
      end
      @(posedge clk); #1;
      xrst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || out_valid || busy) late++;
         @(posedge clk); #1;
      end
      total++;
      if (late !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles, expected 0", late); end
      do_job(0, 2, 1, 0, 1'b0);
      check_words("after_abort", 0, 2, 1);
      total++;
      if (done_cnt !== 1 || first_idx !== 2) begin
         bad++; $display("FAIL after_abort_timing: done %0d first %0d, expected 1 2", done_cnt, first_idx);
      end
   endtask

`ifdef RENKON_FEAT_READER_STRIDE_EN
   task automatic test_stride();
      do_job(1, 3, 3, 0, 1'b0);
      check_words("stride", 1, 3, 3);
   endtask
`endif

   task automatic test_random();
      for (int j = 0; j < 10; j++) begin
         int b = $urandom_range(0, DEPTH - 1);
         int l = $urandom_range(1, 20);
         int s = $urandom_range(0, DEPTH - 1);
         do_job(b, l, s, 2, 1'b1);
         check_words("random", b, l, s);
         total++;
         if (done_cnt !== 1 || stall_bad !== 0 || over2 !== 0 || hold_bad !== 0) begin
            bad++;
            $display("FAIL random_job%0d: done=%0d stall=%0d over=%0d hold=%0d, expected 1 0 0 0",
                     j, done_cnt, stall_bad, over2, hold_bad);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      test_reset();
      test_basic();
      test_len0();
      test_wrap();
      test_stall();
      test_hold();
      test_abort();
`ifdef RENKON_FEAT_READER_STRIDE_EN
      test_stride();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
